led_status: RTL and testbench

LED_STATUS -- requirements
Module: led_status

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/led_status_tick_gen.sv | 35 +++
 rtl/led_status.sv | 165 ++++++++++++++++
 tb/tb_led_status.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch display slice.
//   mode_t        : 2-bit stopwatch mode as driven on current_state
//   disp_state_t  : LED display FSM states (steady/chaser display vs alarm flash)
package stopwatch_pkg;

    typedef enum logic [1:0] {
        UP_WAIT   = 2'b00,
        UP_RUN    = 2'b01,
        DOWN_WAIT = 2'b10,
        DOWN_RUN  = 2'b11
    } mode_t;

    typedef enum logic {
        NORMAL = 1'b0,
        ALARM  = 1'b1
    } disp_state_t;

endpackage

// File: rtl/led_status_tick_gen.sv
// tick_gen
// Display-rate prescaler. Counts 0..TICK_DIV-1 and wraps; tick is high for
// the single cycle in which the count sits at its last value.
// Ports:
//   clk     : system clock (rising edge)
//   rst_n   : synchronous active-low reset, clears the count
//   restart : synchronous clear of the count (wins over counting)
//   tick    : one-cycle strobe when count == TICK_DIV-1
module tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tick = (count_reg == LAST);

endmodule

// File: rtl/led_status.sv
// led_status
// Drives a bank of status LEDs from the stopwatch mode, with an alarm flash
// overlay. Lower half of the bank belongs to "up" modes, upper half to "down".
// Ports:
//   clk           : system clock (rising edge)
//   rst_n         : synchronous active-low reset
//   current_state : stopwatch mode (see stopwatch_pkg::mode_t)
//   alarm_pulse   : request to (re)start the alarm flash; level = request each cycle
//   led           : registered LED drive, 1 = lit
//   alarm_active  : registered, high while the alarm flash runs
module led_status
    import stopwatch_pkg::*;
#(
    parameter int NUM_LEDS      = 4,
    parameter int TICK_DIV      = 25_000_000,
    parameter int ALARM_TOGGLES = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          current_state,
    input  logic                alarm_pulse,
    output logic [NUM_LEDS-1:0] led,
    output logic                alarm_active
);

    localparam int H  = NUM_LEDS / 2;
    // A single-LED half still needs a one-bit position register.
    localparam int PW = (H > 1) ? $clog2(H) : 1;
    localparam int TW = $clog2(ALARM_TOGGLES + 1);
    localparam logic [PW-1:0] P_LAST   = PW'(H - 1);
    localparam logic [TW-1:0] TOG_LAST = TW'(ALARM_TOGGLES);

    mode_t               mode;
    mode_t               prev_mode_reg;
    disp_state_t         state_reg, state_next;
    logic [PW-1:0]       p_reg, p_next, q_reg, q_next;
    logic [TW-1:0]       tog_reg, tog_next, tog_inc;
    logic [NUM_LEDS-1:0] led_reg, led_next;
    logic                active_reg, active_next;
    logic                mode_change, tick, restart, alarm_exit;
    logic [NUM_LEDS-1:0] low_mask, up_onehot, down_onehot, normal_pattern;

    assign mode        = mode_t'(current_state);
    assign mode_change = (mode != prev_mode_reg);
    assign tog_inc     = tog_reg + 1'b1;

    // Flash ends on the tick that completes the last toggle, unless a fresh
    // request arrives in the same cycle.
    assign alarm_exit = (state_reg == ALARM) && !alarm_pulse && tick && (tog_inc == TOG_LAST);

    // Any entry (including a re-request) or exit realigns the tick phase.
    assign restart = mode_change || alarm_pulse || alarm_exit;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    // Chaser positions. They only advance while the display is in NORMAL;
    // a mode change or alarm exit puts them back to their entry values so
    // the pattern always starts fresh.
    always_comb begin
        p_next = p_reg;
        q_next = q_reg;
        if (mode_change || alarm_exit) begin
            p_next = '0;
            q_next = P_LAST;
        end else if ((state_reg == NORMAL) && tick) begin
            if (mode == UP_RUN) begin
                p_next = (p_reg == P_LAST) ? '0 : p_reg + 1'b1;
            end
            if (mode == DOWN_RUN) begin
                q_next = (q_reg == '0) ? P_LAST : q_reg - 1'b1;
            end
        end
    end

    // Per-LED pattern bits: lower half serves up modes, upper half down modes.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
            if (gi < H) begin : g_low
                assign low_mask[gi]    = 1'b1;
                assign up_onehot[gi]   = (p_next == PW'(gi));
                assign down_onehot[gi] = 1'b0;
            end else begin : g_high
                assign low_mask[gi]    = 1'b0;
                assign up_onehot[gi]   = 1'b0;
                assign down_onehot[gi] = (q_next == PW'(gi - H));
            end
        end
    endgenerate

    always_comb begin
        case (mode)
            UP_WAIT:   normal_pattern = low_mask;
            DOWN_WAIT: normal_pattern = ~low_mask;
            UP_RUN:    normal_pattern = up_onehot;
            default:   normal_pattern = down_onehot;
        endcase
    end

    // Display FSM next-state and LED/flag next values.
    always_comb begin
        state_next = state_reg;
        tog_next   = tog_reg;
        led_next   = led_reg;
        case (state_reg)
            NORMAL: begin
                if (alarm_pulse) begin
                    state_next = ALARM;
                    tog_next   = '0;
                    led_next   = '1;
                end else begin
                    led_next = normal_pattern;
                end
            end
            ALARM: begin
                if (alarm_pulse) begin
                    tog_next = '0;
                    led_next = '1;
                end else if (alarm_exit) begin
                    state_next = NORMAL;
                    tog_next   = '0;
                    led_next   = normal_pattern;
                end else if (tick) begin
                    tog_next = tog_inc;
                    led_next = ~led_reg;
                end
            end
            default: begin
                state_next = NORMAL;
                led_next   = normal_pattern;
            end
        endcase
        active_next = (state_next == ALARM);
    end

    always_ff @(posedge clk) begin
        prev_mode_reg <= mode;
        if (!rst_n) begin
            state_reg  <= NORMAL;
            tog_reg    <= '0;
            led_reg    <= '0;
            active_reg <= 1'b0;
            p_reg      <= '0;
            q_reg      <= P_LAST;
        end else begin
            state_reg  <= state_next;
            tog_reg    <= tog_next;
            led_reg    <= led_next;
            active_reg <= active_next;
            p_reg      <= p_next;
            q_reg      <= q_next;
        end
    end

    assign led          = led_reg;
    assign alarm_active = active_reg;

endmodule

// File: tb/tb_led_status.sv
// tb_led_status
// Self-checking bench for led_status (NUM_LEDS=4, TICK_DIV=4, ALARM_TOGGLES=4).
// Each driven cycle pushes the reference model's expected outputs into a
// scoreboard queue; after the clock edge the entry is popped and compared.
module tb_led_status;

    localparam int NL = 4;
    localparam int TD = 4;
    localparam int AT = 4;
    localparam int HH = NL / 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    current_state = 2'b00;
    logic          alarm_pulse = 1'b0;
    logic [NL-1:0] led;
    logic          alarm_active;

    led_status #(
        .NUM_LEDS      (NL),
        .TICK_DIV      (TD),
        .ALARM_TOGGLES (AT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .current_state (current_state),
        .alarm_pulse   (alarm_pulse),
        .led           (led),
        .alarm_active  (alarm_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NL-1:0] led;
        logic          act;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state
    int            m_alarm, m_cnt, m_tog, m_p, m_q;
    logic [NL-1:0] m_led;
    logic          m_act;
    logic [1:0]    m_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [NL-1:0] pattern(input logic [1:0] s, input int p, input int q);
        logic [NL-1:0] one;
        one = 1;
        case (s)
            2'b00:   return (one << HH) - one;
            2'b10:   return ((one << HH) - one) << HH;
            2'b01:   return one << p;
            default: return one << (HH + q);
        endcase
    endfunction

    task automatic model(input logic r, input logic [1:0] s, input logic pulse);
        logic chg, tk, was_alarm, exit_now;
        if (!r) begin
            m_led = '0; m_act = 1'b0; m_alarm = 0; m_cnt = 0; m_tog = 0;
            m_p = 0; m_q = HH - 1; m_prev = s;
            return;
        end
        chg       = (s != m_prev);
        tk        = (m_cnt == TD - 1);
        was_alarm = (m_alarm != 0);
        exit_now  = 1'b0;
        if (pulse) begin
            m_alarm = 1; m_tog = 0; m_led = '1;
        end else if (was_alarm && tk) begin
            m_tog++;
            if (m_tog == AT) begin
                m_alarm = 0; m_tog = 0; exit_now = 1'b1;
            end else begin
                m_led = ~m_led;
            end
        end
        if (chg || exit_now) begin
            m_p = 0; m_q = HH - 1;
        end else if (!was_alarm && tk) begin
            if (s == 2'b01) m_p = (m_p + 1) % HH;
            if (s == 2'b11) m_q = (m_q == 0) ? HH - 1 : m_q - 1;
        end
        if (m_alarm == 0) m_led = pattern(s, m_p, m_q);
        m_cnt  = (chg || pulse || exit_now || tk) ? 0 : m_cnt + 1;
        m_prev = s;
        m_act  = (m_alarm != 0);
    endtask

    // One transaction: drive inputs, push expectation, clock, pop and compare.
    task automatic step(input logic r, input logic [1:0] s, input logic pulse);
        exp_t e;
        rst_n = r; current_state = s; alarm_pulse = pulse;
        model(r, s, pulse);
        e.led = m_led; e.act = m_act;
        sb_q.push_back(e);
        @(posedge clk); #1;
        cyc++;
        e = sb_q.pop_front();
        $display("cyc=%0d rst_n=%0b state=%02b pulse=%0b led=%04b act=%0b exp_led=%04b exp_act=%0b",
                 cyc, r, s, pulse, led, alarm_active, e.led, e.act);
        chk("led", 32'(led), 32'(e.led));
        chk("alarm_active", 32'(alarm_active), 32'(e.act));
    endtask

    initial begin
        @(posedge clk); #1;

        // Reset with state 00, then release
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0);
        chk("reset_led", 32'(led), 32'h0);
        step(1'b1, 2'b00, 1'b0);
        chk("release_led", 32'(led), 32'b0011);

        // Up-run chaser over 16 cycles
        step(1'b1, 2'b01, 1'b0);
        chk("uprun_entry", 32'(led), 32'b0001);
        for (int i = 0; i < 15; i++) step(1'b1, 2'b01, 1'b0);

        // Down-run chaser over 12 cycles
        step(1'b1, 2'b11, 1'b0);
        chk("downrun_entry", 32'(led), 32'b1000);
        for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 1'b0);
        step(1'b1, 2'b11, 1'b0);
        chk("downrun_step", 32'(led), 32'b0100);
        for (int i = 0; i < 7; i++) step(1'b1, 2'b11, 1'b0);

        // Alarm in down_wait: full flash then back to 1100
        for (int i = 0; i < 2; i++) step(1'b1, 2'b10, 1'b0);
        step(1'b1, 2'b10, 1'b1);
        chk("alarm_entry", 32'(led), 32'b1111);
        for (int i = 0; i < 16; i++) step(1'b1, 2'b10, 1'b0);
        chk("alarm_exit_led", 32'(led), 32'b1100);
        chk("alarm_exit_act", 32'(alarm_active), 32'h0);

        // Alarm in up_run, mode 01->00 during flash, re-request 6 cycles in
        for (int i = 0; i < 2; i++) step(1'b1, 2'b01, 1'b0);
        step(1'b1, 2'b01, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 1'b0);
        step(1'b1, 2'b00, 1'b1);
        chk("restart_led", 32'(led), 32'b1111);
        for (int i = 0; i < 16; i++) step(1'b1, 2'b00, 1'b0);
        chk("restart_exit_led", 32'(led), 32'b0011);
        chk("restart_exit_act", 32'(alarm_active), 32'h0);

        // Held alarm level keeps the flash pinned at all-on
        for (int i = 0; i < 6; i++) step(1'b1, 2'b01, 1'b1);
        chk("held_pulse_led", 32'(led), 32'b1111);

        // Reset mid-alarm in up_run
        for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 1'b0);
        step(1'b0, 2'b01, 1'b0);
        chk("midalarm_rst_led", 32'(led), 32'h0);
        chk("midalarm_rst_act", 32'(alarm_active), 32'h0);
        step(1'b1, 2'b01, 1'b0);
        chk("post_rst_led", 32'(led), 32'b0001);

        // Random traffic
        begin
            logic [1:0] s;
            logic       r, pl;
            s = 2'b00;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 7) == 0) s = 2'($urandom_range(0, 3));
                pl = ($urandom_range(0, 24) == 0);
                r  = ($urandom_range(0, 99) != 0);
                step(r, s, pl);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
